game_sequencer: RTL
===================

# game_sequencer

Top-level game-flow controller that sequences the player, enemy and bullet datapaths. It gates frame advancement with `run_o`, pauses play on a player hit, and runs level transitions and life awards. It also restarts the game on the center button. It sits between the button/frame sources and the `player` and enemy blocks; those blocks take their pause, reset and add-life controls from here.

## Interface
Parameters:
- `clear_frames_p`, 120: frames spent in LEVEL_CLEAR before the next level starts.
- `hit_frames_p`, 60: minimum frames in HIT_PAUSE before the start button is accepted.
- `base_interval_p`, 30: enemy step interval (frames) at level 1.
- `min_interval_p`, 4: floor on enemy step interval.

Ports:
- `clk_i` in 1: clock.
- `reset_ni` in 1: reset, synchronous and active-low.
- `frame_i` in 1: one-cycle pulse per video frame.
- `start_i` in 1: center button, level-sensitive and already debounced.
- `player_hit_i` in 1: enemy bullet hit the player (one-cycle pulse).
- `lives_i` in 2: player life count before the hit.
- `wave_clear_i` in 1: all enemies destroyed (level).
- `enemy_at_bottom_i` in 1: enemy formation reached player row (level).
- `run_o` out 1: datapaths may advance on `frame_i`.
- `state_o` out 5: one-hot present state, for debug.
- `level_o` out 4: current level, 1..15.
- `speed_o` out 5: enemy step interval in frames.
- `new_game_o` out 1: one-cycle pulse; resets lives, score and positions.
- `new_level_o` out 1: one-cycle pulse; rebuilds the enemy formation.
- `resume_o` out 1: one-cycle pulse leaving HIT_PAUSE.
- `add_life_o` out 1: life-award request, held as described in Operation.
- `banner_o` out 2: message select. 0 = none, 1 = "PRESS START", 2 = "LEVEL CLEAR", 3 = "GAME OVER".

## Operation
- **Start edge.** `start_q` registers `start_i`. `start_rise = start_i & ~start_q`. Every start-button transition uses `start_rise`, never the level.
- **States.** One-hot, 5 bits: IDLE=00001, PLAY=00010, HIT_PAUSE=00100, LEVEL_CLEAR=01000, GAME_OVER=10000. Any other encoding goes to IDLE on the next cycle.
- **IDLE.** `start_rise` goes to PLAY. That cycle pulses `new_game_o` and `new_level_o` and loads `level_o` = 1. `banner_o` = 1.
- **PLAY.** `run_o` = 1 and `banner_o` = 0. Exit priority, highest first:
  1. `player_hit_i` & `lives_i` == 0 goes to GAME_OVER.
  2. `enemy_at_bottom_i` goes to GAME_OVER.
  3. `player_hit_i` & `lives_i` > 0 goes to HIT_PAUSE.
  4. `wave_clear_i` goes to LEVEL_CLEAR.
  - A simultaneous hit and clear therefore resolves to the hit.
- **HIT_PAUSE.** `run_o` = 0 and `banner_o` = 0. The dwell counter counts `frame_i`. Once it reaches `hit_frames_p`, `start_rise` goes to PLAY and pulses `resume_o`. A `start_rise` before that is ignored.
- **LEVEL_CLEAR.** `run_o` = 0 and `banner_o` = 2.
  - If the level being cleared is even, `add_life_o` is high from the entry cycle through the first cycle with `frame_i` = 1 in this state (inclusive), then low. The consumer therefore sees exactly one `add_life_o & frame_i`.
  - When the dwell counter reaches `clear_frames_p`, the block goes to PLAY. That cycle it pulses `new_level_o` and sets `level_o` = min(`level_o` + 1, 15). The level saturates at 15.
- **GAME_OVER.** `run_o` = 0 and `banner_o` = 3. `start_rise` goes to PLAY with the same actions as the IDLE exit.
- **Speed.** `speed_o` = max(`base_interval_p` − 2·(`level_o` − 1), `min_interval_p`). Compute at 6-bit signed or clamp before subtracting so there is no unsigned wrap. The result is registered, so it updates one cycle after `level_o`.
- **Dwell counter.** 7 bits. Reset to 0 on every state change; increments on `frame_i`.

## Timing
- Reset values with `reset_ni` = 0 at a clock edge:
  - state = IDLE, `level_o` = 1, `speed_o` = `base_interval_p`.
  - Dwell = 0 and `start_q` = 1, so a button held through reset does not start the game.
  - All pulses = 0, `run_o` = 0, `banner_o` = 1.
- Reset asserted mid-state overrides every transition in that cycle.
- The state register updates on `posedge clk_i`. `run_o`, `banner_o` and `state_o` are Moore outputs, decoded from the registered state.
- `new_game_o`, `new_level_o` and `resume_o` are registered. Each is high for exactly the one cycle after the transitioning edge, which is also the first cycle of PLAY.
- Input-event to state-change latency is 1 cycle. `start_rise` adds 1 cycle after the `start_i` rise.

## Structure
- Shared package `game_pkg`: the state enum, the `banner_o` codes, and the `MAX_LEVEL` = 15 constant.
- Dwell timer: instantiate the existing `counter` module (`width_p` = 7, `step_p` = 1). Drive its active-high reset with `~reset_ni | state_change`. The level counter is also a `counter` (`width_p` = 4, `reset_val_p` = 1).

## Test plan
- Reset with `start_i` held high, then release and press again. Expect no start on the held press; the fresh press gives PLAY one cycle after the rise, with `new_game_o` and `new_level_o` each pulsing for 1 cycle and `level_o` = 1.
- In PLAY, `player_hit_i` with `lives_i` = 2. Expect HIT_PAUSE and `run_o` = 0. A start at frame 30 is ignored; a start at frame 61 gives PLAY plus a `resume_o` pulse.
- Clear level 2. Expect `add_life_o` high until the first frame (exactly one frame-coincident cycle). After 120 frames, `level_o` = 3, `speed_o` = 26, and `new_level_o` pulses. Clearing level 1 must produce no `add_life_o`.
- `player_hit_i` and `wave_clear_i` in the same cycle with `lives_i` = 0. Expect GAME_OVER and `banner_o` = 3.
- Reach level 15 and clear it. Expect `level_o` to stay at 15 and `speed_o` = 4 (floor). Assert reset mid-LEVEL_CLEAR: expect IDLE and all outputs at their reset values.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types and constants for the game-flow sequencer:
//                one-hot state encoding, banner message codes, level ceiling
//                and the enemy step-interval helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // One-hot game-flow states; state_o exposes these bits directly.
    typedef enum logic [4:0] {
        ST_IDLE        = 5'b00001,
        ST_PLAY        = 5'b00010,
        ST_HIT_PAUSE   = 5'b00100,
        ST_LEVEL_CLEAR = 5'b01000,
        ST_GAME_OVER   = 5'b10000
    } state_t;

    // Banner message select codes.
    localparam logic [1:0] BANNER_NONE      = 2'd0;
    localparam logic [1:0] BANNER_START     = 2'd1;
    localparam logic [1:0] BANNER_CLEAR     = 2'd2;
    localparam logic [1:0] BANNER_GAME_OVER = 2'd3;

    // Highest reachable level; the level counter stops here.
    localparam logic [3:0] MAX_LEVEL = 4'd15;

    // Enemy step interval: base minus two frames per level above 1, floored.
    // Evaluated in signed int so a high level cannot wrap to a large value.
    function automatic logic [4:0] calc_speed(input logic [3:0] level,
                                              input int        base,
                                              input int        floor_v);
        int v;
        v = base - 2 * int'(level) + 2;
        if (v < floor_v) begin
            v = floor_v;
        end
        return v[4:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// ============================================================================
//  Module      : counter
//  Description : Generic up-counter with synchronous active-high reset to a
//                programmable value and a count enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter #(
    parameter int width_p     = 8,
    parameter int step_p      = 1,
    parameter int reset_val_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    // Reset has priority over the enable so a load and a step never collide.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= width_p'(reset_val_p);
        end else if (en_i) begin
            count_o <= count_o + width_p'(step_p);
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Game-flow controller. Gates datapath frame advance, pauses
//                on a player hit, runs level transitions and life awards and
//                restarts the game on the center button.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
    import game_pkg::*;
#(
    parameter int clear_frames_p  = 120,
    parameter int hit_frames_p    = 60,
    parameter int base_interval_p = 30,
    parameter int min_interval_p  = 4
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       frame_i,
    input  logic       start_i,
    input  logic       player_hit_i,
    input  logic [1:0] lives_i,
    input  logic       wave_clear_i,
    input  logic       enemy_at_bottom_i,
    output logic       run_o,
    output logic [4:0] state_o,
    output logic [3:0] level_o,
    output logic [4:0] speed_o,
    output logic       new_game_o,
    output logic       new_level_o,
    output logic       resume_o,
    output logic       add_life_o,
    output logic [1:0] banner_o
);

    localparam logic [6:0] c_hit_frames   = 7'(hit_frames_p);
    localparam logic [6:0] c_clear_frames = 7'(clear_frames_p);
    localparam logic [6:0] c_dwell_max    = 7'h7F;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_start_q;
    logic       w_start_rise;
    logic       w_state_change;

    logic [6:0] w_dwell;
    logic       w_dwell_rst;
    logic       w_dwell_en;

    logic [3:0] w_level;
    logic       w_level_rst;
    logic       w_level_en;
    logic       w_level_up;

    logic       w_new_game;
    logic       w_new_level;
    logic       w_resume;
    logic       r_new_game;
    logic       r_new_level;
    logic       r_resume;
    logic [4:0] r_speed;

    assign w_start_rise   = start_i & ~r_start_q;
    assign w_state_change = (w_next_state != r_state);

    // Button history; reset to 1 so a press held through reset is not an edge.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_start_q <= 1'b1;
        end else begin
            r_start_q <= start_i;
        end
    end

    // Dwell timer restarts on every state change; it holds at all-ones rather
    // than wrapping so a long pause never drops back below the threshold.
    assign w_dwell_rst = ~reset_ni | w_state_change;
    assign w_dwell_en  = frame_i & (w_dwell != c_dwell_max);

    counter #(
        .width_p     (7),
        .step_p      (1),
        .reset_val_p (0)
    ) u_dwell (
        .clk_i   (clk_i),
        .reset_i (w_dwell_rst),
        .en_i    (w_dwell_en),
        .count_o (w_dwell)
    );

    // Level reloads to 1 on a new game and advances on a clear until 15.
    assign w_level_rst = ~reset_ni | w_new_game;
    assign w_level_en  = w_level_up & (w_level != MAX_LEVEL);

    counter #(
        .width_p     (4),
        .step_p      (1),
        .reset_val_p (1)
    ) u_level (
        .clk_i   (clk_i),
        .reset_i (w_level_rst),
        .en_i    (w_level_en),
        .count_o (w_level)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection and the transition pulses that accompany it.
    always_comb begin
        w_next_state = r_state;
        w_new_game   = 1'b0;
        w_new_level  = 1'b0;
        w_resume     = 1'b0;
        w_level_up   = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAME_OVER: begin
                if (w_start_rise) begin
                    w_next_state = ST_PLAY;
                    w_new_game   = 1'b1;
                    w_new_level  = 1'b1;
                end
            end
            ST_PLAY: begin
                // A hit outranks a clear in the same cycle.
                if (player_hit_i && (lives_i == 2'd0)) begin
                    w_next_state = ST_GAME_OVER;
                end else if (enemy_at_bottom_i) begin
                    w_next_state = ST_GAME_OVER;
                end else if (player_hit_i) begin
                    w_next_state = ST_HIT_PAUSE;
                end else if (wave_clear_i) begin
                    w_next_state = ST_LEVEL_CLEAR;
                end
            end
            ST_HIT_PAUSE: begin
                if ((w_dwell >= c_hit_frames) && w_start_rise) begin
                    w_next_state = ST_PLAY;
                    w_resume     = 1'b1;
                end
            end
            ST_LEVEL_CLEAR: begin
                if (w_dwell >= c_clear_frames) begin
                    w_next_state = ST_PLAY;
                    w_new_level  = 1'b1;
                    w_level_up   = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Registered transition pulses and the speed derived from the level.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_new_game  <= 1'b0;
            r_new_level <= 1'b0;
            r_resume    <= 1'b0;
            r_speed     <= 5'(base_interval_p);
        end else begin
            r_new_game  <= w_new_game;
            r_new_level <= w_new_level;
            r_resume    <= w_resume;
            r_speed     <= calc_speed(w_level, base_interval_p, min_interval_p);
        end
    end

    // Moore decode of run and banner from the registered state.
    always_comb begin
        run_o    = 1'b0;
        banner_o = BANNER_START;
        case (r_state)
            ST_IDLE:        banner_o = BANNER_START;
            ST_PLAY: begin
                run_o    = 1'b1;
                banner_o = BANNER_NONE;
            end
            ST_HIT_PAUSE:   banner_o = BANNER_NONE;
            ST_LEVEL_CLEAR: banner_o = BANNER_CLEAR;
            ST_GAME_OVER:   banner_o = BANNER_GAME_OVER;
            default:        banner_o = BANNER_START;
        endcase
    end

    // Life award on even levels: the dwell counter is still zero from the
    // entry cycle up to and including the first frame cycle in the state.
    assign add_life_o = (r_state == ST_LEVEL_CLEAR) & ~w_level[0] & (w_dwell == 7'd0);

    assign state_o     = r_state;
    assign level_o     = w_level;
    assign speed_o     = r_speed;
    assign new_game_o  = r_new_game;
    assign new_level_o = r_new_level;
    assign resume_o    = r_resume;

endmodule
`default_nettype wire
